// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, IR field positions, ALU strobe indices and sequencer states
package cpu_ctrl_pkg;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;
    localparam int ALU_W    = 13;
    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_MUL  = 4;
    localparam int ALU_DIV  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;
    // One-hot ALU strobe for an opcode; zero for codes with no ALU operation
    function automatic logic [ALU_W-1:0] alu_sel(input logic [4:0] op);
        logic [ALU_W-1:0] s;
        s = '0;
        case (op)
            OP_AND:  s[ALU_AND]  = 1'b1;
            OP_OR:   s[ALU_OR]   = 1'b1;
            OP_ADD:  s[ALU_ADD]  = 1'b1;
            OP_SUB:  s[ALU_SUB]  = 1'b1;
            OP_MUL:  s[ALU_MUL]  = 1'b1;
            OP_DIV:  s[ALU_DIV]  = 1'b1;
            OP_SHR:  s[ALU_SHR]  = 1'b1;
            OP_SHRA: s[ALU_SHRA] = 1'b1;
            OP_SHL:  s[ALU_SHL]  = 1'b1;
            OP_ROR:  s[ALU_ROR]  = 1'b1;
            OP_ROL:  s[ALU_ROL]  = 1'b1;
            OP_NEG:  s[ALU_NEG]  = 1'b1;
            OP_NOT:  s[ALU_NOT]  = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: sequencer <-> datapath/memory control bundle
//   inputs to sequencer: run, mem_rdy, ir
//   outputs from sequencer: Rout/Rin one-hot GPR selects, bus drives, register loads,
//   Read, IncPC, alu_op strobes, halted
interface control_unit_if #(parameter int NREGS = 16, parameter int DW = 32);
    import cpu_ctrl_pkg::*;
    logic             run;
    logic             mem_rdy;
    logic [DW-1:0]    ir;
    logic [NREGS-1:0] Rout;
    logic [NREGS-1:0] Rin;
    logic             PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
    logic             PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic             Read, IncPC;
    logic [ALU_W-1:0] alu_op;
    logic             halted;
    modport master (
        output run, mem_rdy, ir,
        input  Rout, Rin, PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
               PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Read, IncPC, alu_op, halted
    );
    modport slave (
        input  run, mem_rdy, ir,
        output Rout, Rin, PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
               PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Read, IncPC, alu_op, halted
    );
endinterface

// File: rtl/control_unit_reg_field_decode.sv
// reg_field_decode: 4-bit register field + enable -> one-hot register select
//   field in 4, en in 1, onehot out NREGS (all zero when en is low)
module reg_field_decode #(parameter int NREGS = 16) (
    input  logic [3:0]       field,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);
    assign onehot = en ? (NREGS'(1) << field) : '0;
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer (RST, T0..T6, HALT)
//   clk, reset (sync, active-high); bus: control_unit_if slave
//   Optional ILLEGAL_OP_TRAP_EN: illegal opcode in T3 traps into HALT; otherwise it is a NOP
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 32
) (
    input logic          clk,
    input logic          reset,
    control_unit_if.slave bus
);
    state_t     state;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       two_op, mul_div, unary, legal;
    logic       rout_en, rin_en;
    assign op      = bus.ir[OP_HI:OP_LO];
    assign ra      = bus.ir[RA_HI:RA_LO];
    assign rb      = bus.ir[RB_HI:RB_LO];
    assign rc      = bus.ir[RC_HI:RC_LO];
    assign mul_div = (op == OP_MUL) || (op == OP_DIV);
    assign unary   = (op == OP_NEG) || (op == OP_NOT);
    assign two_op  = ((op >= OP_ADD) && (op <= OP_SHL)) || mul_div;
    assign legal   = two_op || unary;
    // Rb goes out in T3, Rc in T4; results land in Ra in T4 (unary) or T5 (ALU two-operand)
    assign rout_en = ((state == S_T3) && legal) || ((state == S_T4) && two_op);
    assign rin_en  = ((state == S_T4) && unary) || ((state == S_T5) && two_op && !mul_div);
    reg_field_decode #(.NREGS(NREGS)) u_rout (
        .field  (state == S_T4 ? rc : rb),
        .en     (rout_en),
        .onehot (bus.Rout)
    );
    reg_field_decode #(.NREGS(NREGS)) u_rin (
        .field  (ra),
        .en     (rin_en),
        .onehot (bus.Rin)
    );
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_RST;
        else
            case (state)
                S_RST:  state <= S_T0;
                S_T0:   state <= bus.run ? S_T1 : S_T0;
                S_T1:   state <= bus.mem_rdy ? S_T2 : S_T1;
                S_T2:   state <= S_T3;
`ifdef ILLEGAL_OP_TRAP_EN
                S_T3:   state <= legal ? S_T4 : S_HALT;
`else
                S_T3:   state <= legal ? S_T4 : S_T0;
`endif
                S_T4:   state <= unary ? S_T0 : S_T5;
                S_T5:   state <= mul_div ? S_T6 : S_T0;
                S_T6:   state <= S_T0;
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
    end
    always_comb begin
        bus.PCout    = (state == S_T0) && bus.run;
        bus.MARin    = (state == S_T0) && bus.run;
        bus.IncPC    = (state == S_T0) && bus.run;
        bus.Read     = (state == S_T1);
        bus.MDRin    = (state == S_T1) && bus.mem_rdy;
        bus.PCin     = (state == S_T1) && bus.mem_rdy;
        bus.MDRout   = (state == S_T2);
        bus.IRin     = (state == S_T2);
        bus.Yin      = (state == S_T3) && two_op;
        bus.Zin      = ((state == S_T0) && bus.run) || ((state == S_T3) && unary) ||
                       ((state == S_T4) && two_op);
        bus.alu_op   = ((state == S_T3) && unary) || ((state == S_T4) && two_op) ? alu_sel(op) : '0;
        bus.Zlowout  = ((state == S_T1) && bus.mem_rdy) || ((state == S_T4) && unary) ||
                       ((state == S_T5) && two_op);
        bus.LOin     = (state == S_T5) && mul_div;
        bus.Zhighout = (state == S_T6);
        bus.HIin     = (state == S_T6);
        bus.HIout    = 1'b0;
        bus.LOout    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        bus.halted   = (state == S_HALT);
`else
        bus.halted   = 1'b0;
`endif
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random instruction stream against a per-cycle reference schedule
module tb_control_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    control_unit_if #(.NREGS(16), .DW(32)) bus ();
    control_unit #(.NREGS(16), .DW(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic        pcout, mdrout, zhighout, zlowout, hiout, loout;
        logic        pcin, irin, marin, mdrin, yin, zin, hiin, loin;
        logic        read, incpc;
        logic [12:0] alu;
        logic        halted;
    } ov_t;
    function automatic ov_t snap();
        ov_t o;
        o = {bus.Rout, bus.Rin, bus.PCout, bus.MDRout, bus.Zhighout, bus.Zlowout, bus.HIout,
             bus.LOout, bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.Zin, bus.HIin,
             bus.LOin, bus.Read, bus.IncPC, bus.alu_op, bus.halted};
        return o;
    endfunction
    // ALU strobe position for each opcode, from the one-hot order NOT..AND (MSB..LSB)
    function automatic logic [12:0] alu_of(input logic [4:0] op);
        int k;
        case (op)
            5'd5:  k = 0;
            5'd6:  k = 1;
            5'd3:  k = 2;
            5'd4:  k = 3;
            5'd15: k = 4;
            5'd16: k = 5;
            5'd9:  k = 6;
            5'd10: k = 7;
            5'd11: k = 8;
            5'd7:  k = 9;
            5'd8:  k = 10;
            5'd17: k = 11;
            5'd18: k = 12;
            default: k = -1;
        endcase
        return (k < 0) ? 13'd0 : (13'd1 << k);
    endfunction
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step(input string tag, input ov_t e);
        @(negedge clk);
        check(tag, 64'(snap()), 64'(e));
        @(posedge clk);
        #1;
    endtask
    // Starts in T0; returns with the sequencer back in T0
    task automatic run_instr(input logic [31:0] i, input int waits, input bit abort4);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         md, un, two;
        ov_t        e;
        op  = i[31:27];
        ra  = i[26:23];
        rb  = i[22:19];
        rc  = i[18:15];
        md  = (op == 5'd15) || (op == 5'd16);
        un  = (op == 5'd17) || (op == 5'd18);
        two = ((op >= 5'd3) && (op <= 5'd11)) || md;
        bus.ir = i;
        bus.run = 1'b1;
        bus.mem_rdy = 1'($urandom);
        e = '0; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
        step("t0_fetch", e);
        bus.run = 1'($urandom);
        for (int w = 0; w < waits; w++) begin
            bus.mem_rdy = 1'b0;
            e = '0; e.read = 1;
            step("t1_wait", e);
        end
        bus.mem_rdy = 1'b1;
        e = '0; e.read = 1; e.mdrin = 1; e.zlowout = 1; e.pcin = 1;
        step("t1_rdy", e);
        bus.mem_rdy = 1'($urandom);
        e = '0; e.mdrout = 1; e.irin = 1;
        step("t2", e);
        if (!(two || un)) begin
            e = '0;
            step("t3_illegal", e);
`ifdef ILLEGAL_OP_TRAP_EN
            e.halted = 1;
            for (int h = 0; h < 3; h++) step("halt_hold", e);
            reset = 1'b1;
            step("halt_in_reset", e);
            reset = 1'b0;
            e = '0;
            step("halt_cleared", e);
`endif
            return;
        end
        e = '0; e.rout = 16'd1 << rb;
        if (un) begin e.alu = alu_of(op); e.zin = 1; end
        else e.yin = 1;
        step("t3", e);
        e = '0;
        if (un) begin e.zlowout = 1; e.rin = 16'd1 << ra; end
        else begin e.rout = 16'd1 << rc; e.alu = alu_of(op); e.zin = 1; end
        if (abort4) reset = 1'b1;
        step("t4", e);
        if (abort4) begin
            reset = 1'b0;
            e = '0;
            step("abort_rst", e);
            return;
        end
        if (un) return;
        e = '0; e.zlowout = 1;
        if (md) e.loin = 1;
        else e.rin = 16'd1 << ra;
        step("t5", e);
        if (!md) return;
        e = '0; e.zhighout = 1; e.hiin = 1;
        step("t6", e);
    endtask
    initial begin
        logic [31:0] i;
        reset = 1'b1;
        bus.run = 1'b0;
        bus.mem_rdy = 1'b0;
        bus.ir = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        step("reset_hold", '0);
        reset = 1'b0;
        step("rst_state", '0);
        step("idle_t0", '0);
        step("idle_t0", '0);
        run_instr(32'h2A1B8000, 0, 1'b0);
        run_instr(32'h2A1B8000, 3, 1'b0);
        run_instr(32'h78188000, 1, 1'b0);
        run_instr(32'h92900000, 0, 1'b0);
        run_instr(32'hF8000000, 0, 1'b0);
        run_instr({5'd3, 4'd2, 4'd6, 4'd6, 15'd0}, 2, 1'b1);
        bus.run = 1'b0;
        for (int k = 0; k < 3; k++) step("idle_after_rst", '0);
        for (int n = 0; n < 80; n++) begin
            i = $urandom;
            if ($urandom_range(0, 2) != 0) i[31:27] = 5'($urandom_range(3, 18));
            run_instr(i, $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) begin
                bus.run = 1'b0;
                bus.mem_rdy = 1'($urandom);
                step("idle_rand", '0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
